// File: rtl/adc_frame_aligner.sv
// Bitslip alignment controller for multi-lane LVDS ADC receivers.
// Watches the deserialised frame-lane word and strobes a common bitslip to
// every ISERDES lane until the frame word matches FRAME_PATTERN, then holds
// lock, monitors for lock loss and re-aligns automatically.
module adc_frame_aligner #(
  parameter int                    NUM_LANES     = 8,
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = 10'b1111100000,
  parameter int                    SLIP_WAIT     = 4,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    LOSS_COUNT    = 4,
  parameter int                    MAX_SLIPS     = 2 * DATA_WIDTH
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic [DATA_WIDTH-1:0]            frame_i,
  input  logic                             frame_valid_i,
  input  logic                             start_i,
  output logic [NUM_LANES:0]               bitslip_o,
  output logic                             bitslip_done,
  output logic                             align_error_o,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count_o,
  output logic [7:0]                       relock_count_o
);

  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_COUNT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [SLIP_W-1:0]  SLIP_MAX  = SLIP_W'(MAX_SLIPS);

  typedef enum logic [2:0] {
    CHECK  = 3'd0,
    SLIP   = 3'd1,
    WAIT   = 3'd2,
    LOCKED = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t             state_q,  state_d;
  logic [MATCH_W-1:0] match_q,  match_d;
  logic [MISS_W-1:0]  miss_q,   miss_d;
  logic [WAIT_W-1:0]  wait_q,   wait_d;
  logic [SLIP_W-1:0]  slip_q,   slip_d;
  logic [7:0]         relock_q, relock_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;

  logic frame_match;

  assign frame_match = (frame_i == FRAME_PATTERN);

  // Next-state and counter logic; start_i overrides everything except reset
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    miss_d   = miss_q;
    wait_d   = wait_q;
    slip_d   = slip_q;
    relock_d = relock_q;
    done_d   = done_q;
    err_d    = err_q;

    if (start_i) begin
      state_d  = CHECK;
      match_d  = '0;
      miss_d   = '0;
      wait_d   = '0;
      slip_d   = '0;
      relock_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        CHECK: begin
          if (frame_valid_i) begin
            if (frame_match) begin
              if (match_q == LOCK_LAST) begin
                state_d = LOCKED;
                done_d  = 1'b1;
                match_d = '0;
                miss_d  = '0;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              match_d = '0;
              if (slip_q == SLIP_MAX) begin
                state_d = ERROR;
                err_d   = 1'b1;
                done_d  = 1'b0;
              end else begin
                state_d = SLIP;
              end
            end
          end
        end

        SLIP: begin
          if (slip_q != SLIP_MAX) begin
            slip_d = slip_q + 1'b1;
          end
          wait_d  = '0;
          state_d = WAIT;
        end

        WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            match_d = '0;
            state_d = CHECK;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end

        LOCKED: begin
          if (frame_valid_i) begin
            if (frame_match) begin
              miss_d = '0;
            end else if (miss_q == LOSS_LAST) begin
              done_d  = 1'b0;
              miss_d  = '0;
              match_d = '0;
              slip_d  = '0;
              if (relock_q != 8'hFF) begin
                relock_d = relock_q + 1'b1;
              end
              state_d = SLIP;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end

        ERROR: begin
          err_d  = 1'b1;
          done_d = 1'b0;
        end

        default: begin
          state_d = CHECK;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= CHECK;
      match_q  <= '0;
      miss_q   <= '0;
      wait_q   <= '0;
      slip_q   <= '0;
      relock_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      relock_q <= relock_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // The bitslip strobe is a pure state decode, so it lasts exactly one cycle
  assign bitslip_o      = {(NUM_LANES + 1){state_q == SLIP}};
  assign bitslip_done   = done_q;
  assign align_error_o  = err_q;
  assign slip_count_o   = slip_q;
  assign relock_count_o = relock_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner with a simple ISERDES rotation model.
module tb_adc_frame_aligner;

  localparam int NUM_LANES  = 8;
  localparam int DATA_WIDTH = 10;
  localparam int SLIP_WAIT  = 4;
  localparam int LOCK_COUNT = 16;
  localparam int LOSS_COUNT = 4;
  localparam int MAX_SLIPS  = 20;
  localparam logic [9:0] PAT = 10'b1111100000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  frame_i = '0;
  logic        frame_valid_i = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  bitslip_o;
  logic        bitslip_done;
  logic        align_error_o;
  logic [4:0]  slip_count_o;
  logic [7:0]  relock_count_o;

  int checks = 0;
  int fails = 0;
  int cycle = 0;
  int phase = 0;
  int rot = 3;
  int pulses = 0;
  int last_pulse = -1000;
  int match_seen = 0;
  int ign = 0;
  int guard = 0;
  int pulses_snap = 0;
  logic prev_done = 1'b0;
  logic const_mode = 1'b0;
  logic inject = 1'b0;

  adc_frame_aligner #(
    .NUM_LANES(NUM_LANES), .DATA_WIDTH(DATA_WIDTH), .FRAME_PATTERN(PAT),
    .SLIP_WAIT(SLIP_WAIT), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT),
    .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_i(frame_i),
    .frame_valid_i(frame_valid_i), .start_i(start_i), .bitslip_o(bitslip_o),
    .bitslip_done(bitslip_done), .align_error_o(align_error_o),
    .slip_count_o(slip_count_o), .relock_count_o(relock_count_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Frame word as seen by the receiver after n uncorrected bit positions
  function automatic logic [9:0] rotl(input logic [9:0] p, input int n);
    logic [9:0] r;
    r = p;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one clock cycle of stimulus, then monitor the strobe and the lock latency
  task automatic applyStimulus(input logic rst, input logic st);
    @(negedge sys_clk);
    sys_rst = rst;
    start_i = st;
    frame_valid_i = (phase == 0);
    if (!frame_valid_i)  frame_i = ~PAT;
    else if (const_mode) frame_i = 10'h155;
    else if (inject)     frame_i = ~PAT;
    else                 frame_i = rotl(PAT, rot);
    phase = (phase == 4) ? 0 : phase + 1;
    @(posedge sys_clk);
    #1;
    cycle++;
    checkOutput("bitslip_uniform", 32'((bitslip_o == 9'h000) || (bitslip_o == 9'h1FF)), 1);
    if (rst || st) begin
      last_pulse = -1000;
      match_seen = 0;
      ign = 0;
    end else if (bitslip_o != 9'h000) begin
      checkOutput("bitslip_spacing", 32'((cycle - last_pulse) >= SLIP_WAIT + 2), 1);
      last_pulse = cycle;
      pulses++;
      rot = (rot == 0) ? DATA_WIDTH - 1 : rot - 1;
      match_seen = 0;
      ign = SLIP_WAIT + 1;
    end else if (ign > 0) begin
      ign--;
    end else if (!prev_done && frame_valid_i) begin
      match_seen = (frame_i == PAT) ? match_seen + 1 : 0;
    end
    if (bitslip_done && !prev_done && !rst && !st)
      checkOutput("lock_latency", match_seen, LOCK_COUNT);
    prev_done = bitslip_done;
  endtask

  // Present n valid frame words, the remaining cycles being invalid filler
  task automatic runValidWords(input int n);
    int cnt;
    int g;
    cnt = 0;
    g = 0;
    while (cnt < n && g < 200) begin
      applyStimulus(1'b0, 1'b0);
      if (frame_valid_i) cnt++;
      g++;
    end
    checkOutput("valid_words_presented", cnt, n);
  endtask

  task automatic waitLock(input int limit);
    guard = 0;
    while (!bitslip_done && guard < limit) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("lock_reached", bitslip_done, 1);
  endtask

  task automatic waitPulse(input int limit);
    guard = 0;
    do begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end while (bitslip_o == 9'h000 && guard < limit);
    checkOutput("pulse_seen", 32'(bitslip_o == 9'h1FF), 1);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("rst_done", bitslip_done, 0);
    checkOutput("rst_err", align_error_o, 0);
    checkOutput("rst_slip", slip_count_o, 0);
    checkOutput("rst_relock", relock_count_o, 0);
    checkOutput("rst_bitslip", bitslip_o, 0);

    // Frame rotated by three positions, automatic search after reset
    rot = 3;
    pulses = 0;
    waitLock(600);
    checkOutput("t1_pulses", pulses, 3);
    checkOutput("t1_slip", slip_count_o, 3);
    checkOutput("t1_err", align_error_o, 0);
    checkOutput("t1_relock", relock_count_o, 0);

    // Never-matching frame exhausts the search
    const_mode = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_start_slip", slip_count_o, 0);
    checkOutput("t2_start_done", bitslip_done, 0);
    pulses = 0;
    guard = 0;
    while (!align_error_o && guard < 2000) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("t2_err", align_error_o, 1);
    checkOutput("t2_pulses", pulses, MAX_SLIPS);
    checkOutput("t2_slip", slip_count_o, MAX_SLIPS);
    checkOutput("t2_done", bitslip_done, 0);
    pulses_snap = pulses;
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t2_no_more_pulses", pulses, pulses_snap);
    checkOutput("t2_err_sticky", align_error_o, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_err_cleared", align_error_o, 0);
    checkOutput("t2_slip_cleared", slip_count_o, 0);
    checkOutput("t2_no_bitslip", bitslip_o, 0);

    // Lock, then tolerate isolated mismatches and recover from a real loss
    const_mode = 1'b0;
    rot = 2;
    applyStimulus(1'b0, 1'b1);
    waitLock(600);
    checkOutput("t3_slip", slip_count_o, 2);
    inject = 1'b1;
    runValidWords(3);
    inject = 1'b0;
    runValidWords(1);
    checkOutput("t3_held_done", bitslip_done, 1);
    checkOutput("t3_held_relock", relock_count_o, 0);
    inject = 1'b1;
    runValidWords(4);
    inject = 1'b0;
    checkOutput("t3_loss_done", bitslip_done, 0);
    checkOutput("t3_loss_relock", relock_count_o, 1);
    checkOutput("t3_loss_slip", slip_count_o, 0);
    checkOutput("t3_loss_bitslip", bitslip_o, 9'h1FF);
    waitLock(1500);
    checkOutput("t3_relock_slip", slip_count_o, 10);
    checkOutput("t3_relock_count", relock_count_o, 1);

    // start_i while locked and while waiting
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_locked_done", bitslip_done, 0);
    checkOutput("t4_locked_relock", relock_count_o, 0);
    checkOutput("t4_locked_slip", slip_count_o, 0);
    checkOutput("t4_locked_bitslip", bitslip_o, 0);
    rot = 1;
    waitPulse(50);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_wait_slip", slip_count_o, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_wait_start_slip", slip_count_o, 0);
    checkOutput("t4_wait_start_bitslip", bitslip_o, 0);
    waitLock(600);
    checkOutput("t4_relock_slip", slip_count_o, 0);

    // Synchronous reset while a slip is being issued
    rot = 2;
    applyStimulus(1'b0, 1'b1);
    waitPulse(50);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_bitslip", bitslip_o, 0);
    checkOutput("t5_slip", slip_count_o, 0);
    checkOutput("t5_done", bitslip_done, 0);
    checkOutput("t5_err", align_error_o, 0);
    checkOutput("t5_relock", relock_count_o, 0);
    waitLock(600);
    checkOutput("t5_final_slip", slip_count_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
